pwm_duty_capture: RTL and testbench

- Receive-side counterpart of the fan PWM generator: samples a PWM line and recovers the 8-bit duty value that produced it.
- Measures the high time and the period of each frame, and reports the duty with a one-cycle valid strobe.
- Flags frames whose period is off-nominal, and reports stuck-low / stuck-high lines as 0x00 / 0xFF.
- Sits on the fan feedback/loopback path for closed-loop monitoring and self-test.

---
 rtl/pwm_duty_capture_pkg.sv | 46 ++++
 rtl/pwm_duty_capture_in_cond.sv | 85 ++++++++
 rtl/pwm_duty_capture.sv | 137 +++++++++++++
 tb/tb_pwm_duty_capture.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_duty_capture_pkg.sv
`default_nettype none
// =============================================================================
// Package  : pwm_pkg
// Purpose  : Shared constants, state encoding, report record and the duty
//            saturation helper for the PWM duty capture block.
// Contents : PWM_PERIOD / PWM_TOL   nominal frame length and period tolerance
//            DUTY_W / DUTY_MAX      duty word width and saturation value
//            ST_IDLE/ST_HIGH/ST_LOW 2-bit FSM encoding
//            pwm_report_t           one measurement report (duty, err, stuck)
//            sat_duty()             clamp a high-time count into DUTY_W bits
// Revision : 1.0 - initial release
// =============================================================================
package pwm_pkg;

    localparam int PWM_PERIOD = 256;
    localparam int PWM_TOL    = 2;

    localparam int DUTY_W = 8;
    localparam logic [DUTY_W-1:0] DUTY_MAX = 8'hFF;
    localparam logic [DUTY_W-1:0] DUTY_MIN = 8'h00;

    // Width of the argument taken by sat_duty(); callers size-cast into it.
    localparam int SAT_IN_W = 16;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;  // waiting for first rise
    localparam logic [STATE_W-1:0] ST_HIGH = 2'd1;  // inside the high phase
    localparam logic [STATE_W-1:0] ST_LOW  = 2'd2;  // inside the low phase

    typedef struct packed {
        logic [DUTY_W-1:0] duty;
        logic              period_err;
        logic              stuck;
        logic              valid;
    } pwm_report_t;

    // High time counts above the duty range saturate rather than wrap.
    function automatic logic [DUTY_W-1:0] sat_duty(input logic [SAT_IN_W-1:0] cnt);
        if (cnt > SAT_IN_W'(DUTY_MAX)) begin
            return DUTY_MAX;
        end
        return cnt[DUTY_W-1:0];
    endfunction

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_duty_capture_in_cond.sv
`default_nettype none
// =============================================================================
// Module   : pwm_in_cond
// Purpose  : Input conditioning for the PWM capture path: brings the
//            asynchronous PWM line into the clk domain, optionally removes
//            single-cycle glitches, and produces rise/fall pulses.
// Ports    : clk      in   system clock, rising edge
//            arst     in   asynchronous active-high reset
//            pwm_i    in   raw asynchronous PWM line
//            pwm_s_o  out  conditioned (synchronised, optionally filtered) level
//            rise_o   out  one-cycle pulse on a 0->1 transition of pwm_s_o
//            fall_o   out  one-cycle pulse on a 1->0 transition of pwm_s_o
// Macro    : PWM_CAPTURE_FILTER_EN - when defined, a 2-sample glitch filter
//            sits behind the synchroniser (adds 2 clocks of latency).
// Revision : 1.0 - initial release
// =============================================================================
module pwm_in_cond (
    input  logic clk,
    input  logic arst,
    input  logic pwm_i,
    output logic pwm_s_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic pwm_d_q;
    logic w_pwm_s;

    // Two-flop synchroniser; sync1_q may go metastable, nothing else reads it.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pwm_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    logic hist_q;
    logic filt_q;
    logic filt_d;

    // The filtered level only follows the synchronised line once the current
    // and previous samples agree, so a level held for a single clock never
    // reaches the edge detector.
    always_comb begin
        filt_d = filt_q;
        if (sync2_q == hist_q) begin
            filt_d = sync2_q;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            hist_q <= 1'b0;
            filt_q <= 1'b0;
        end else begin
            hist_q <= sync2_q;
            filt_q <= filt_d;
        end
    end

    assign w_pwm_s = filt_q;
`else
    assign w_pwm_s = sync2_q;
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pwm_d_q <= 1'b0;
        end else begin
            pwm_d_q <= w_pwm_s;
        end
    end

    assign pwm_s_o = w_pwm_s;
    assign rise_o  =  w_pwm_s & ~pwm_d_q;
    assign fall_o  = ~w_pwm_s &  pwm_d_q;

endmodule : pwm_in_cond
`default_nettype wire

// File: rtl/pwm_duty_capture.sv
`default_nettype none
// =============================================================================
// Module   : pwm_duty_capture
// Purpose  : Recovers the 8-bit duty value from a sampled PWM line. Each frame
//            (rise to rise) is timed; on frame completion the high time is
//            reported with a one-cycle valid strobe and the period checked
//            against PERIOD +/- TOL. A line with no rising edge for
//            PERIOD+TOL clocks is reported as stuck (0x00 low / 0xFF high).
// Ports    : clk         in   system clock, rising edge
//            arst        in   asynchronous active-high reset
//            pwm_in      in   asynchronous PWM line
//            duty        out  last measured duty (high clocks, sat. at 255)
//            duty_valid  out  one-cycle pulse when duty/period_err/stuck update
//            period_err  out  last frame period outside PERIOD +/- TOL
//            stuck       out  last update came from a timeout, not a frame
// Params   : PERIOD  nominal frame length in clk cycles
//            TOL     allowed period deviation before period_err
//            CW      counter width, must hold PERIOD+TOL
// Macro    : PWM_CAPTURE_FILTER_EN - enables the input glitch filter inside
//            pwm_in_cond (valid latency 5 clocks instead of 3).
// Revision : 1.0 - initial release
// =============================================================================
module pwm_duty_capture
    import pwm_pkg::*;
#(
    parameter int PERIOD = PWM_PERIOD,
    parameter int TOL    = PWM_TOL,
    parameter int CW     = 9
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_valid,
    output logic              period_err,
    output logic              stuck
);

    localparam logic [CW-1:0] c_PER_MAX = CW'(PERIOD + TOL);
    localparam logic [CW-1:0] c_PER_MIN = CW'(PERIOD - TOL);
    localparam logic [CW-1:0] c_ONE     = CW'(1);

    logic              w_pwm_s;
    logic              w_rise;
    logic              w_fall;
    logic              w_timeout;

    logic [STATE_W-1:0] state_q,   state_d;
    logic [CW-1:0]      hi_cnt_q,  hi_cnt_d;
    logic [CW-1:0]      per_cnt_q, per_cnt_d;
    pwm_report_t        rpt_q,     rpt_d;

    pwm_in_cond u_in_cond (
        .clk     (clk),
        .arst    (arst),
        .pwm_i   (pwm_in),
        .pwm_s_o (w_pwm_s),
        .rise_o  (w_rise),
        .fall_o  (w_fall)
    );

    // A rise in the same cycle as the timeout completes the frame instead,
    // so a frame of exactly PERIOD+TOL clocks is still measured.
    assign w_timeout = (per_cnt_q == c_PER_MAX) & ~w_rise;

    always_comb begin
        state_d      = state_q;
        hi_cnt_d     = hi_cnt_q;
        per_cnt_d    = per_cnt_q + c_ONE;
        rpt_d        = rpt_q;
        rpt_d.valid  = 1'b0;

        if (w_rise) begin
            // Only a rise seen from LOW closes a fully observed frame; from
            // IDLE the frame that starts here is merely timed.
            if (state_q == ST_LOW) begin
                rpt_d.duty       = sat_duty(SAT_IN_W'(hi_cnt_q));
                rpt_d.period_err = (per_cnt_q < c_PER_MIN) | (per_cnt_q > c_PER_MAX);
                rpt_d.stuck      = 1'b0;
                rpt_d.valid      = 1'b1;
            end
            state_d   = ST_HIGH;
            hi_cnt_d  = c_ONE;
            per_cnt_d = c_ONE;
        end else if (w_timeout) begin
            rpt_d.duty       = w_pwm_s ? DUTY_MAX : DUTY_MIN;
            rpt_d.period_err = 1'b0;
            rpt_d.stuck      = 1'b1;
            rpt_d.valid      = 1'b1;
            state_d   = ST_IDLE;
            hi_cnt_d  = '0;
            per_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_HIGH: begin
                    // The fall cycle is already low, so it is not high time.
                    if (w_fall) begin
                        state_d = ST_LOW;
                    end else begin
                        hi_cnt_d = hi_cnt_q + c_ONE;
                    end
                end
                ST_LOW: begin
                    state_d = ST_LOW;
                end
                default: begin
                    state_d  = ST_IDLE;
                    hi_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= ST_IDLE;
            hi_cnt_q  <= '0;
            per_cnt_q <= '0;
            rpt_q     <= '0;
        end else begin
            state_q   <= state_d;
            hi_cnt_q  <= hi_cnt_d;
            per_cnt_q <= per_cnt_d;
            rpt_q     <= rpt_d;
        end
    end

    assign duty       = rpt_q.duty;
    assign duty_valid = rpt_q.valid;
    assign period_err = rpt_q.period_err;
    assign stuck      = rpt_q.stuck;

endmodule : pwm_duty_capture
`default_nettype wire

// File: tb/tb_pwm_duty_capture.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : tb_pwm_duty_capture
// Purpose  : Self-checking bench for pwm_duty_capture. Every clock the DUT
//            outputs are compared against an event/timestamp reference model;
//            a vector table and hand sequences check reported values directly.
// Macro    : PWM_CAPTURE_FILTER_EN - selects filtered-line expectations.
// Revision : 1.0 - initial release
// =============================================================================
module tb_pwm_duty_capture;
    import pwm_pkg::*;

    localparam int c_PER  = 256;
    localparam int c_TOL  = 2;
    localparam int c_TMO  = c_PER + c_TOL;
    localparam int c_HMAX = 32768;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int c_LAG  = 3;
    localparam bit c_FILT = 1'b1;
    localparam int c_LAT  = 5;
`else
    localparam int c_LAG  = 2;
    localparam bit c_FILT = 1'b0;
    localparam int c_LAT  = 3;
`endif

    logic       clk = 1'b0;
    logic       arst;
    logic       pwm_in;
    logic [7:0] duty;
    logic       duty_valid;
    logic       period_err;
    logic       stuck;

    pwm_duty_capture #(.PERIOD(c_PER), .TOL(c_TOL), .CW(9)) dut (
        .clk        (clk),
        .arst       (arst),
        .pwm_in     (pwm_in),
        .duty       (duty),
        .duty_valid (duty_valid),
        .period_err (period_err),
        .stuck      (stuck)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Level history indexed by clock edge: raw samples and glitch-filtered view.
    bit raw_h [c_HMAX];
    bit flt_h [c_HMAX];
    int k = 16;

    // Reference model: frame timestamps rather than counters.
    int       m_anchor;     // edge at which the period count was zero
    int       m_rise_t;
    int       m_fall_t;
    bit       m_open;       // a rise has been seen since reset/timeout
    bit       m_fell;       // the open frame has had its falling edge
    bit       m_valid;
    bit [7:0] m_duty;
    bit       m_err;
    bit       m_stuck;

    int       cap_n;
    bit [7:0] cap_duty;
    bit       cap_err;
    bit       cap_stuck;
    int       err_rep;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (edge %0d, t=%0t)", name, act, exp, k, $time);
        end
    endtask

    function automatic bit lvl(input int j);
        return c_FILT ? flt_h[j] : raw_h[j];
    endfunction

    task automatic model_step();
        bit cur;
        bit prv;
        int p;
        int h;
        cur = lvl(k - c_LAG);
        prv = lvl(k - c_LAG - 1);
        p = k - m_anchor;
        m_valid = 1'b0;
        if (cur && !prv) begin
            if (m_open && m_fell) begin
                h       = m_fall_t - m_rise_t;
                m_duty  = (h > 255) ? 8'hFF : h[7:0];
                m_err   = (p < c_PER - c_TOL) || (p > c_TMO);
                m_stuck = 1'b0;
                m_valid = 1'b1;
            end
            m_open   = 1'b1;
            m_fell   = 1'b0;
            m_rise_t = k;
            m_anchor = k;
        end else if (p == c_TMO) begin
            m_duty   = cur ? 8'hFF : 8'h00;
            m_stuck  = 1'b1;
            m_err    = 1'b0;
            m_valid  = 1'b1;
            m_open   = 1'b0;
            m_fell   = 1'b0;
            m_anchor = k + 1;
        end else if (m_open && !m_fell && !cur && prv) begin
            m_fell   = 1'b1;
            m_fall_t = k;
        end
    endtask

    task automatic model_clear();
        for (int j = k - 8; j <= k; j++) begin
            raw_h[j] = 1'b0;
            flt_h[j] = 1'b0;
        end
        m_open = 1'b0; m_fell = 1'b0; m_valid = 1'b0;
        m_duty = 8'h00; m_err = 1'b0; m_stuck = 1'b0;
        m_anchor = k + 1;
    endtask

    // One clock: drive the level, let the edge happen, step the model, compare.
    task automatic tick(input bit l);
        pwm_in = l;
        @(posedge clk);
        k++;
        raw_h[k] = l;
        flt_h[k] = (raw_h[k] == raw_h[k-1]) ? raw_h[k] : flt_h[k-1];
        model_step();
        #1;
        check("outputs(valid,duty,err,stuck)", {duty_valid, duty, period_err, stuck},
              {m_valid, m_duty, m_err, m_stuck});
        if (duty_valid === 1'b1) begin
            cap_n++;
            cap_duty  = duty;
            cap_err   = period_err;
            cap_stuck = stuck;
            if (period_err === 1'b1) err_rep++;
        end
    endtask

    task automatic frame(input int hi, input int per);
        for (int i = 0; i < per; i++) tick(i < hi);
    endtask

    task automatic pulse_reset();
        arst = 1'b1;
        #1;
        check("rst_immediate", {duty_valid, duty, period_err, stuck}, 11'd0);
        @(posedge clk);
        k++;
        #1;
        check("rst_hold", {duty_valid, duty, period_err, stuck}, 11'd0);
        arst = 1'b0;
        model_clear();
    endtask

    typedef struct {
        int       hi;
        int       per;
        int       nfr;
        bit [7:0] exp_duty;
        bit       exp_err;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat_n;
        bit got;
        int per_r;
        int hi_r;

        vecs[0] = '{204, 256, 3, 8'hCC, 1'b0};
        vecs[1] = '{238, 256, 2, 8'hEE, 1'b0};
        vecs[2] = '{100, 250, 2, 8'd100, 1'b1};
        vecs[3] = '{128, 256, 2, 8'd128, 1'b0};
        vecs[4] = '{3,   256, 2, 8'd3,   1'b0};
        vecs[5] = '{254, 256, 2, 8'd254, 1'b0};
        vecs[6] = '{128, 254, 2, 8'd128, 1'b0};
        vecs[7] = '{128, 253, 2, 8'd128, 1'b1};
        vecs[8] = '{256, 258, 2, 8'hFF,  1'b0};   // saturation + rise/timeout tie
        vecs[9] = '{2,   4,   4, 8'd2,   1'b1};

        arst = 1'b1;
        pwm_in = 1'b0;
        cap_n = 0; cap_duty = 8'h00; cap_err = 1'b0; cap_stuck = 1'b0; err_rep = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {duty_valid, duty, period_err, stuck}, 11'd0);
        arst = 1'b0;
        model_clear();

        for (int i = 0; i < 10; i++) begin
            cap_n = 0;
            repeat (vecs[i].nfr) frame(vecs[i].hi, vecs[i].per);
            check($sformatf("vec%0d_reported", i), (cap_n > 0), 1);
            check($sformatf("vec%0d_duty", i), cap_duty, vecs[i].exp_duty);
            check($sformatf("vec%0d_err", i), cap_err, vecs[i].exp_err);
            check($sformatf("vec%0d_stuck", i), cap_stuck, 1'b0);
        end

        // Latency from the raw rising edge to duty_valid.
        repeat (10) tick(1'b0);
        lat_n = 0;
        got = 1'b0;
        for (int n = 1; n <= 20 && !got; n++) begin
            tick(1'b1);
            if (duty_valid === 1'b1) begin
                got = 1'b1;
                lat_n = n;
            end
        end
        check("latency", lat_n, c_LAT);
        for (int n = lat_n; n < 100; n++) tick(1'b1);
        repeat (156) tick(1'b0);

        // A frame longer than PERIOD+TOL times out before its closing rise.
        frame(100, 300);
        check("long_frame_stuck", cap_stuck, 1'b1);
        check("long_frame_duty", cap_duty, 8'h00);
        check("long_frame_err", cap_err, 1'b0);
        frame(128, 256);
        frame(128, 256);
        check("after_long_duty", cap_duty, 8'd128);
        check("after_long_err", cap_err, 1'b0);
        check("after_long_stuck", cap_stuck, 1'b0);

        // Line stuck low, then stuck high.
        cap_n = 0;
        repeat (600) tick(1'b0);
        check("stuck_low_reports", (cap_n >= 2), 1);
        check("stuck_low_duty", cap_duty, 8'h00);
        check("stuck_low_flag", cap_stuck, 1'b1);
        cap_n = 0;
        repeat (600) tick(1'b1);
        check("stuck_high_reported", (cap_n > 0), 1);
        check("stuck_high_duty", cap_duty, 8'hFF);
        check("stuck_high_flag", cap_stuck, 1'b1);
        repeat (50) tick(1'b0);

        // Reset pulse in the middle of a high phase.
        frame(128, 256);
        frame(128, 256);
        repeat (50) tick(1'b1);
        pulse_reset();
        repeat (77) tick(1'b1);
        repeat (128) tick(1'b0);
        repeat (3) frame(128, 256);
        check("post_reset_duty", cap_duty, 8'd128);
        check("post_reset_err", cap_err, 1'b0);
        check("post_reset_stuck", cap_stuck, 1'b0);

        // One-clock low glitch inside a high phase.
        err_rep = 0;
        repeat (60) tick(1'b1);
        tick(1'b0);
        repeat (67) tick(1'b1);
        repeat (128) tick(1'b0);
        frame(128, 256);
        frame(128, 256);
`ifdef PWM_CAPTURE_FILTER_EN
        check("glitch_err_reports", err_rep, 0);
`else
        check("glitch_err_seen", (err_rep > 0), 1);
`endif
        check("glitch_final_duty", cap_duty, 8'd128);
        check("glitch_final_err", cap_err, 1'b0);

        // Randomised frames, mostly near nominal with occasional extremes.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) per_r = int'($urandom_range(2, 300));
            else                           per_r = int'($urandom_range(250, 262));
            hi_r = int'($urandom_range(1, per_r - 1));
            frame(hi_r, per_r);
        end
        frame(128, 256);
        frame(128, 256);
        check("random_tail_duty", cap_duty, 8'd128);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pwm_duty_capture
`default_nettype wire
